mcu_ctrl: RTL and testbench



---
 rtl/mcu_ctrl_if.sv | 23 ++
 rtl/mcu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mcu_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_ctrl_if.sv
// Memory-side bus of the MCU sequencer: instruction fetch port and data-memory handshake.
interface mcu_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 8
);
  logic                  imem_rd;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_data;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic                  dmem_ack;

  modport master (
    output imem_rd, imem_addr, dmem_req, dmem_we, dmem_addr,
    input  imem_data, dmem_ack
  );

  modport slave (
    input  imem_rd, imem_addr, dmem_req, dmem_we, dmem_addr,
    output imem_data, dmem_ack
  );
endinterface

// File: rtl/mcu_ctrl.sv
// mcu_ctrl: program counter and fetch/operand/memory/execute sequencer of the accumulator MCU.
// Define MCU_CTRL_WDOG_EN to abort data-memory accesses whose ack never arrives.
module mcu_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INST_WIDTH  = 8,
  parameter int RESET_PC    = 0,
  parameter int WDOG_CYCLES = 16,
  parameter int PSR_WIDTH   = 4,
  parameter int RES_COUNT   = 3,
  parameter int REG_COUNT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mcu_ctrl_if.master            bus,
  input  logic [PSR_WIDTH-1:0]  psr,
  output logic                  opcode_update,
  output logic                  imem_update,
  output logic                  dmem_update,
  output logic                  psr_update,
  output logic                  res_update,
  output logic [RES_COUNT-1:0]  res_sel,
  output logic [REG_COUNT-1:0]  opa_sel,
  output logic [REG_COUNT-1:0]  opb_sel,
  output logic [1:0]            alu_op,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  err
);
  // Selectors are one-hot towards the register bank.
  localparam logic [RES_COUNT-1:0] RES_ALU  = RES_COUNT'(1);
  localparam logic [RES_COUNT-1:0] RES_DMEM = RES_COUNT'(2);
  localparam logic [RES_COUNT-1:0] RES_IMEM = RES_COUNT'(4);
  localparam logic [REG_COUNT-1:0] REG_ACC  = REG_COUNT'(1);
  localparam logic [REG_COUNT-1:0] REG_IMEM = REG_COUNT'(2);
  localparam logic [REG_COUNT-1:0] REG_DMEM = REG_COUNT'(4);

  typedef enum logic [2:0] {
    S_FETCH, S_LATCH, S_OPRD, S_OPLATCH, S_MEMRD, S_MEMWR, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_LDM, OP_STM, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI,
    OP_ADDM, OP_SUBM, OP_JMP, OP_JZ, OP_RSVC, OP_RSVD, OP_RSVE, OP_HALT
  } opcode_t;

  state_t                state, state_nx;
  opcode_t               opcode;
  opcode_t               cur_op;
  logic [ADDR_WIDTH-1:0] operand;
  logic [ADDR_WIDTH-1:0] pc_nx;
  logic [ADDR_WIDTH-1:0] imm;
  logic                  imem_rd, dmem_req, dmem_we;
  logic                  wdog_expired;
  logic                  unused_psr;

  assign cur_op        = opcode_t'(bus.imem_data[INST_WIDTH-1 -: 4]);
  assign imm           = ADDR_WIDTH'(bus.imem_data);
  assign bus.imem_rd   = imem_rd;
  assign bus.imem_addr = pc;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.dmem_addr = operand;
  assign halted        = (state == S_HALT);
  assign unused_psr    = ^psr[PSR_WIDTH-1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      pc      <= ADDR_WIDTH'(RESET_PC);
      opcode  <= OP_NOP;
      operand <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (opcode_update) opcode <= cur_op;
      if (imem_update) operand <= imm;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    imem_rd       = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    opcode_update = 1'b0;
    imem_update   = 1'b0;
    dmem_update   = 1'b0;
    psr_update    = 1'b0;
    res_update    = 1'b0;
    res_sel       = RES_ALU;
    opa_sel       = REG_ACC;
    opb_sel       = REG_IMEM;
    alu_op        = 2'd0;
    case (state)
      S_FETCH: begin
        imem_rd  = 1'b1;
        state_nx = S_LATCH;
      end
      S_LATCH: begin
        opcode_update = 1'b1;
        if (cur_op == OP_HALT) begin
          state_nx = S_HALT;
        end else begin
          pc_nx = pc + 1'b1;
          case (cur_op)
            OP_NOP, OP_RSVC, OP_RSVD, OP_RSVE: state_nx = S_FETCH;
            default:                           state_nx = S_OPRD;
          endcase
        end
      end
      S_OPRD: begin
        imem_rd  = 1'b1;
        state_nx = S_OPLATCH;
      end
      S_OPLATCH: begin
        imem_update = 1'b1;
        pc_nx       = pc + 1'b1;
        state_nx    = S_FETCH;
        case (opcode)
          OP_LDI: begin
            res_update = 1'b1;
            res_sel    = RES_IMEM;
          end
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_nx = S_EXEC;
          OP_LDM, OP_ADDM, OP_SUBM:          state_nx = S_MEMRD;
          OP_STM:                            state_nx = S_MEMWR;
          OP_JMP:                            pc_nx = imm;
          OP_JZ:   if (psr[0]) pc_nx = imm;
          default: ;
        endcase
      end
      S_MEMRD: begin
        dmem_req = 1'b1;
        if (bus.dmem_ack) begin
          dmem_update = 1'b1;
          if (opcode == OP_LDM) begin
            res_update = 1'b1;
            res_sel    = RES_DMEM;
            state_nx   = S_FETCH;
          end else begin
            state_nx = S_EXEC;
          end
        end else if (wdog_expired) begin
          state_nx = S_HALT;
        end
      end
      S_MEMWR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        opa_sel  = REG_ACC;
        if (bus.dmem_ack) state_nx = S_FETCH;
        else if (wdog_expired) state_nx = S_HALT;
      end
      S_EXEC: begin
        opb_sel    = (opcode == OP_ADDM || opcode == OP_SUBM) ? REG_DMEM : REG_IMEM;
        res_sel    = RES_ALU;
        res_update = 1'b1;
        psr_update = 1'b1;
        alu_op     = opcode[1:0];
        state_nx   = S_FETCH;
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

`ifdef MCU_CTRL_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_cnt;
  logic          err_q;
  logic          in_mem;

  assign in_mem       = (state == S_MEMRD) || (state == S_MEMWR);
  assign wdog_expired = in_mem && !bus.dmem_ack && (wdog_cnt == CW'(WDOG_CYCLES - 1));
  assign err          = err_q;

  // Counts consecutive un-acked access cycles; the abort leaves err set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else if (in_mem && !bus.dmem_ack) begin
      wdog_cnt <= wdog_cnt + CW'(1);
      if (wdog_expired) err_q <= 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end
`else
  localparam int unused_wdog = WDOG_CYCLES;
  assign wdog_expired = 1'b0;
  assign err          = 1'b0;
`endif
endmodule

// File: tb/tb_mcu_ctrl.sv
// Scoreboard bench for mcu_ctrl: expected per-cycle outputs are queued, then popped each cycle.
module tb_mcu_ctrl;
  localparam int K_F = 0, K_L = 1, K_R = 2, K_O = 3, K_OI = 4, K_MR = 5, K_MRA = 6,
                 K_MRL = 7, K_MW = 8, K_EI = 9, K_EM = 10, K_H = 11, K_HE = 12;

  typedef struct {
    logic [30:0] v;
    bit          chk_addr;
    logic [7:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  psr;
  logic [7:0]  mem [256];
  int          ack_cnt;
  bit          ack_en;
  int          ack_delay;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sbq[$];

  logic        opcode_update, imem_update, dmem_update, psr_update, res_update;
  logic [2:0]  res_sel;
  logic [3:0]  opa_sel, opb_sel;
  logic [1:0]  alu_op;
  logic [7:0]  pc;
  logic        halted, err;
  logic        h_opcode_update, h_imem_update, h_dmem_update, h_psr_update, h_res_update;
  logic [2:0]  h_res_sel;
  logic [3:0]  h_opa_sel, h_opb_sel;
  logic [1:0]  h_alu_op;
  logic [7:0]  h_pc;
  logic        h_halted, h_err;
  logic [30:0] obs, obs_hi;

  mcu_ctrl_if #(.ADDR_WIDTH(8), .INST_WIDTH(8)) bus ();
  mcu_ctrl_if #(.ADDR_WIDTH(8), .INST_WIDTH(8)) bus_hi ();

  mcu_ctrl #(.ADDR_WIDTH(8), .INST_WIDTH(8), .RESET_PC(0), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .psr(psr),
    .opcode_update(opcode_update), .imem_update(imem_update), .dmem_update(dmem_update),
    .psr_update(psr_update), .res_update(res_update), .res_sel(res_sel),
    .opa_sel(opa_sel), .opb_sel(opb_sel), .alu_op(alu_op), .pc(pc),
    .halted(halted), .err(err)
  );

  mcu_ctrl #(.ADDR_WIDTH(8), .INST_WIDTH(8), .RESET_PC(8'hFE), .WDOG_CYCLES(16)) dut_hi (
    .clk(clk), .rst(rst), .bus(bus_hi), .psr(psr),
    .opcode_update(h_opcode_update), .imem_update(h_imem_update), .dmem_update(h_dmem_update),
    .psr_update(h_psr_update), .res_update(h_res_update), .res_sel(h_res_sel),
    .opa_sel(h_opa_sel), .opb_sel(h_opb_sel), .alu_op(h_alu_op), .pc(h_pc),
    .halted(h_halted), .err(h_err)
  );

  always #5 clk = ~clk;

  assign obs = {err, halted, bus.imem_rd, opcode_update, imem_update, dmem_update, psr_update,
                res_update, res_sel, opa_sel, opb_sel, alu_op, bus.dmem_req, bus.dmem_we, pc};
  assign obs_hi = {h_err, h_halted, bus_hi.imem_rd, h_opcode_update, h_imem_update,
                   h_dmem_update, h_psr_update, h_res_update, h_res_sel, h_opa_sel, h_opb_sel,
                   h_alu_op, bus_hi.dmem_req, bus_hi.dmem_we, h_pc};

  // Instruction memory answers one cycle after the read strobe; data memory acks after ack_delay.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];
    if (bus_hi.imem_rd) bus_hi.imem_data <= mem[bus_hi.imem_addr];
    if (!bus.dmem_req) ack_cnt <= 0;
    else ack_cnt <= ack_cnt + 1;
  end
  assign bus.dmem_ack    = ack_en && bus.dmem_req && (ack_cnt == ack_delay);
  assign bus_hi.dmem_ack = 1'b0;

  function automatic logic [30:0] mk(input int k, input logic [7:0] p, input logic [1:0] a = 2'd0);
    logic e = 0, h = 0, rd = 0, ou = 0, iu = 0, du = 0, pu = 0, ru = 0, rq = 0, we = 0;
    logic [2:0] rs = 3'b001;
    logic [3:0] oa = 4'b0001, ob = 4'b0010;
    logic [1:0] ao = 2'd0;
    case (k)
      K_F, K_R: rd = 1;
      K_L:      ou = 1;
      K_O:      iu = 1;
      K_OI:     begin iu = 1; ru = 1; rs = 3'b100; end
      K_MR:     rq = 1;
      K_MRA:    begin rq = 1; du = 1; end
      K_MRL:    begin rq = 1; du = 1; ru = 1; rs = 3'b010; end
      K_MW:     begin rq = 1; we = 1; end
      K_EI:     begin ru = 1; pu = 1; ao = a; end
      K_EM:     begin ru = 1; pu = 1; ob = 4'b0100; ao = a; end
      K_H:      h = 1;
      K_HE:     begin h = 1; e = 1; end
      default:  ;
    endcase
    return {e, h, rd, ou, iu, du, pu, ru, rs, oa, ob, ao, rq, we, p};
  endfunction

  task automatic push(input int k, input logic [7:0] p, input logic [1:0] a = 2'd0,
                      input bit ca = 1'b0, input logic [7:0] ad = 8'h00);
    exp_t e;
    e.v = mk(k, p, a);
    e.chk_addr = ca;
    e.addr = ad;
    sbq.push_back(e);
  endtask

  task automatic load(input logic [127:0] bytes, input int n);
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    for (int i = 0; i < n; i++) mem[i] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_check(input string name, input bit hi);
    exp_t e;
    logic [30:0] act;
    int idx = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = hi ? obs_hi : obs;
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s cycle %0d: got %b, expected %b", name, idx, act, e.v);
      end
      if (e.chk_addr) begin
        vectors++;
        if (bus.dmem_addr !== e.addr) begin
          miscompares++;
          $display("[TB] FAIL %s cycle %0d dmem_addr: got %h, expected %h", name, idx,
                   bus.dmem_addr, e.addr);
        end
      end
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    load(128'h0, 0);
    #12;
    rst = 1'b0;
    #1;
    vectors += 3;
    if (obs !== mk(K_F, 8'h00)) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b, expected %b", obs, mk(K_F, 8'h00));
    end
    if (obs_hi !== mk(K_F, 8'hFE)) begin
      miscompares++;
      $display("[TB] FAIL reset_pc_hi: got %b, expected %b", obs_hi, mk(K_F, 8'hFE));
    end
    if (bus.dmem_addr !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_operand: got %h, expected 00", bus.dmem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    push(K_F, 8'h00);
    push(K_L, 8'h00);
    run_check("reset_release", 0);
  endtask

  task automatic test_ldi_addi();
    load({8'h10, 8'h05, 8'h40, 8'h03, 8'hF0}, 5);
    do_reset();
    push(K_F, 0); push(K_L, 0); push(K_R, 1); push(K_OI, 1);
    push(K_F, 2); push(K_L, 2); push(K_R, 3); push(K_O, 3); push(K_EI, 4, 2'd0);
    push(K_F, 4); push(K_L, 4); push(K_H, 4); push(K_H, 4);
    run_check("ldi_addi_halt", 0);
  endtask

  task automatic test_ldm_wait();
    load({8'h20, 8'h80}, 2);
    ack_delay = 3;
    do_reset();
    push(K_F, 0); push(K_L, 0); push(K_R, 1); push(K_O, 1);
    for (int i = 0; i < 3; i++) push(K_MR, 2, 2'd0, 1'b1, 8'h80);
    push(K_MRL, 2, 2'd0, 1'b1, 8'h80);
    push(K_F, 2);
    run_check("ldm_wait", 0);
    ack_delay = 0;
  endtask

  task automatic test_jz();
    load({8'hB0, 8'h10}, 2);
    psr = 4'b0001;
    do_reset();
    push(K_F, 0); push(K_L, 0); push(K_R, 1); push(K_O, 1); push(K_F, 8'h10);
    run_check("jz_taken", 0);
    psr = 4'b1110;
    do_reset();
    push(K_F, 0); push(K_L, 0); push(K_R, 1); push(K_O, 1); push(K_F, 8'h02);
    run_check("jz_not_taken", 0);
    psr = 4'b0000;
  endtask

  task automatic test_wrap();
    load(128'h0, 0);
    mem[8'hFE] = 8'hA0;
    mem[8'hFF] = 8'h10;
    do_reset();
    push(K_F, 8'hFE); push(K_L, 8'hFE); push(K_R, 8'hFF); push(K_O, 8'hFF);
    push(K_F, 8'h10); push(K_L, 8'h10); push(K_H, 8'h10);
    run_check("jmp_top", 1);
    mem[8'hFE] = 8'h00;
    mem[8'hFF] = 8'h00;
    do_reset();
    push(K_F, 8'hFE); push(K_L, 8'hFE); push(K_F, 8'hFF); push(K_L, 8'hFF);
    push(K_F, 8'h00); push(K_L, 8'h00); push(K_H, 8'h00);
    run_check("nop_wrap", 1);
  endtask

  task automatic test_back_to_back();
    load({8'h80, 8'h10, 8'h90, 8'h11, 8'h60, 8'h0F, 8'h70, 8'h01,
          8'h00, 8'hC0, 8'h30, 8'h22, 8'hF0}, 13);
    do_reset();
    push(K_F, 0); push(K_L, 0); push(K_R, 1); push(K_O, 1);
    push(K_MRA, 2, 2'd0, 1'b1, 8'h10); push(K_EM, 2, 2'd0);
    push(K_F, 2); push(K_L, 2); push(K_R, 3); push(K_O, 3);
    push(K_MRA, 4, 2'd0, 1'b1, 8'h11); push(K_EM, 4, 2'd1);
    push(K_F, 4); push(K_L, 4); push(K_R, 5); push(K_O, 5); push(K_EI, 6, 2'd2);
    push(K_F, 6); push(K_L, 6); push(K_R, 7); push(K_O, 7); push(K_EI, 8, 2'd3);
    push(K_F, 8); push(K_L, 8); push(K_F, 9); push(K_L, 9);
    push(K_F, 10); push(K_L, 10); push(K_R, 11); push(K_O, 11);
    push(K_MW, 12, 2'd0, 1'b1, 8'h22);
    push(K_F, 12); push(K_L, 12); push(K_H, 12);
    run_check("back_to_back", 0);
  endtask

  task automatic test_rst_mid();
    load({8'h30, 8'h40}, 2);
    ack_en = 1'b0;
    do_reset();
    push(K_F, 0); push(K_L, 0); push(K_R, 1); push(K_O, 1);
    push(K_MW, 2, 2'd0, 1'b1, 8'h40); push(K_MW, 2, 2'd0, 1'b1, 8'h40);
    run_check("stm_pending", 0);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== mk(K_F, 8'h00)) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_async: got %b, expected %b", obs, mk(K_F, 8'h00));
    end
    @(negedge clk);
    rst = 1'b1;
    push(K_F, 0); push(K_L, 0);
    run_check("rst_mid_restart", 0);
    ack_en = 1'b1;
  endtask

  task automatic test_stall();
    load({8'h30, 8'h40}, 2);
    ack_en = 1'b0;
    do_reset();
    push(K_F, 0); push(K_L, 0); push(K_R, 1); push(K_O, 1);
`ifdef MCU_CTRL_WDOG_EN
    for (int i = 0; i < 16; i++) push(K_MW, 2, 2'd0, 1'b1, 8'h40);
    push(K_HE, 2); push(K_HE, 2);
    run_check("wdog_abort", 0);
`else
    for (int i = 0; i < 100; i++) push(K_MW, 2, 2'd0, 1'b1, 8'h40);
    run_check("stall_forever", 0);
`endif
    ack_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    psr = 4'b0000;
    ack_en = 1'b1;
    ack_delay = 0;
    test_reset();
    test_ldi_addi();
    test_ldm_wait();
    test_jz();
    test_wrap();
    test_back_to_back();
    test_rst_mid();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
